mc_control_fsm: RTL and testbench

- Multicycle sequencer for the MIPS datapath.
- Replaces the single-cycle opcode decoder with a state machine. It issues per-cycle control for the shared ALU, a single memory port, the IR, the PC and the register file.
- Stalls on a memory ready handshake.
- Traps on illegal opcodes and memory timeouts.

---
 rtl/mc_control_fsm.sv | 252 +++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle control sequencer for the MIPS datapath. It walks each
//   instruction through FETCH / DECODE / execute / memory / write-back steps
//   and drives the per-cycle control for the shared ALU, the single memory
//   port, the IR, the PC and the register file. Memory steps stall until
//   mem_ready and trap if the memory stays silent too long. Illegal opcodes
//   also trap. A trap is left only through reset.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   run             permits the start of a new instruction fetch
//   opcode          IR[31:26], sampled in DECODE
//   zero            ALU zero flag (the datapath gates PCWriteCond with it)
//   mem_ready       memory completes the access this cycle
//   mem_req, IorD, MemRead, MemWrite        memory port control
//   IRWrite, PCWrite, PCWriteCond, PCSource PC / IR update control
//   ALUSrcA, ALUSrcB, AOp                   ALU operand and operation select
//   RegDs, MtoR, Urw                        register file write control
//   instr_done      one-cycle pulse on the last cycle of each instruction
//   err             sticky: 00 none, 01 illegal opcode, 10 memory timeout
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] AOp,
    output logic       RegDs,
    output logic       MtoR,
    output logic       Urw,
    output logic       instr_done,
    output logic [1:0] err
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
        S_MEM_WR, S_R_EXEC, S_I_EXEC, S_ALU_WB, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             timeout;

    // The branch decision itself is made in the datapath (PCWriteCond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // A ready on the timeout cycle wins, so the trap condition needs !mem_ready.
    assign timeout = (cnt_q == TIMEOUT_CNT) && !mem_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, opcode latch, wait counter and sticky error.
    // NOTE: every variable gets a default at the top so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:                          state_d = S_R_EXEC;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        state_d = S_TRAP;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_R_EXEC, S_I_EXEC:             state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH:   state_d = run ? S_FETCH : S_IDLE;
            S_TRAP:                         state_d = S_TRAP;
            default:                        state_d = S_IDLE;
        endcase

        // Counter restarts on entry to a memory step and counts stalled cycles
        // while the FSM stays in that step.
        if (is_mem_state(state_d) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (is_mem_state(state_q) && (state_d == state_q) && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Moore/Mealy output decode straight from state, op_q and mem_ready.
    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        AOp         = 3'b000;
        RegDs       = 1'b0;
        MtoR        = 1'b0;
        Urw         = 1'b0;
        instr_done  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                AOp     = 3'b011;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                AOp     = 3'b011;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                AOp     = 3'b011;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MtoR       = 1'b1;
                Urw        = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                AOp     = 3'b010;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ADDI: AOp = 3'b011;
                    OP_ANDI: AOp = 3'b101;
                    OP_ORI:  AOp = 3'b110;
                    OP_SLTI: AOp = 3'b100;
                    default: AOp = 3'b000;
                endcase
            end
            S_ALU_WB: begin
                RegDs      = (op_q == OP_RTYPE);
                Urw        = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                AOp         = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Random instruction stream with random memory wait states. The driver
//   pushes the expected latency and final-cycle control of each instruction
//   into a scoreboard; a monitor pops and compares on every instr_done.
//   Directed sequences cover reset, traps and the timeout boundary.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUSrcB, err;
    logic       ALUSrcA, RegDs, MtoR, Urw, instr_done;
    logic [2:0] AOp;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AOp(AOp), .RegDs(RegDs),
        .MtoR(MtoR), .Urw(Urw), .instr_done(instr_done), .err(err)
    );

    always #5 clk = ~clk;

    int cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    typedef struct packed {
        logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write, pc_wc;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] aop;
        logic       reg_ds, mtor, urw, done;
    } outs_t;

    typedef struct {
        int    start;
        int    lat;
        int    fetch_cycles;
        outs_t prev;
        outs_t fin;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.mem_req = mem_req;   o.iord = IorD;        o.mem_read = MemRead;
        o.mem_write = MemWrite; o.ir_write = IRWrite; o.pc_write = PCWrite;
        o.pc_wc = PCWriteCond; o.pc_src = PCSource;  o.src_a = ALUSrcA;
        o.src_b = ALUSrcB;     o.aop = AOp;          o.reg_ds = RegDs;
        o.mtor = MtoR;         o.urw = Urw;          o.done = instr_done;
        return o;
    endfunction

    // ---------------- reference model: control per step from the spec table
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req = 1; o.mem_read = 1; o.src_b = 2'b01; o.aop = 3'b011;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t o_decode();
        outs_t o = '0;
        o.src_b = 2'b11; o.aop = 3'b011;
        return o;
    endfunction
    function automatic outs_t o_alu(input logic [1:0] srcb, input logic [2:0] aop);
        outs_t o = '0;
        o.src_a = 1; o.src_b = srcb; o.aop = aop;
        return o;
    endfunction
    function automatic outs_t o_wb(input logic rd, input logic mtor);
        outs_t o = '0;
        o.reg_ds = rd; o.mtor = mtor; o.urw = 1; o.done = 1;
        return o;
    endfunction
    function automatic outs_t o_mem(input logic wr, input logic rdy);
        outs_t o = '0;
        o.mem_req = 1; o.iord = 1; o.mem_read = !wr; o.mem_write = wr;
        o.done = wr & rdy;
        return o;
    endfunction
    function automatic outs_t o_branch();
        outs_t o = o_alu(2'b00, 3'b001);
        o.pc_wc = 1; o.pc_src = 2'b01; o.done = 1;
        return o;
    endfunction
    function automatic logic [2:0] i_aop(input logic [5:0] op);
        case (op)
            6'h08:   return 3'b011;
            6'h0c:   return 3'b101;
            6'h0d:   return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input int fw, input int mw, input int start);
        exp_t e;
        e.start = start;
        e.fetch_cycles = fw + 1;
        case (op)
            6'h00: begin e.lat = fw + 4; e.prev = o_alu(2'b00, 3'b010); e.fin = o_wb(1, 0); end
            6'h23: begin e.lat = fw + mw + 5; e.prev = o_mem(0, 1); e.fin = o_wb(0, 0); e.fin.mtor = 1; end
            6'h2b: begin
                e.lat  = fw + mw + 4;
                e.prev = (mw == 0) ? o_alu(2'b10, 3'b011) : o_mem(1, 0);
                e.fin  = o_mem(1, 1);
            end
            6'h04: begin e.lat = fw + 3; e.prev = o_decode(); e.fin = o_branch(); end
            default: begin e.lat = fw + 4; e.prev = o_alu(2'b10, i_aop(op)); e.fin = o_wb(0, 0); end
        endcase
        return e;
    endfunction

    // ---------------- monitor
    initial begin : monitor
        outs_t cur, prev_o;
        int ir_cnt, pc_cnt, f_cnt;
        exp_t e;
        prev_o = '0; ir_cnt = 0; pc_cnt = 0; f_cnt = 0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (!rst_n || !sb_en) begin
                ir_cnt = 0; pc_cnt = 0; f_cnt = 0;
            end else begin
                if ((MemRead & MemWrite) || (int'(Urw) + int'(PCWrite) + int'(PCWriteCond) > 1)) begin
                    check("exclusive_strobes", 32'(cur), 32'(0));
                end
                ir_cnt += int'(IRWrite);
                pc_cnt += int'(PCWrite);
                f_cnt  += int'(mem_req & !IorD);
                if (instr_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(1), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check("latency", 32'(cycle_no - e.start + 1), 32'(e.lat));
                        check("final_ctrl", 32'(cur), 32'(e.fin));
                        check("prev_ctrl", 32'(prev_o), 32'(e.prev));
                        check("fetch_cycles", 32'(f_cnt), 32'(e.fetch_cycles));
                        check("irwrite_cnt", 32'(ir_cnt), 32'(1));
                        check("pcwrite_cnt", 32'(pc_cnt), 32'(1));
                    end
                    ir_cnt = 0; pc_cnt = 0; f_cnt = 0;
                end else if (sb.size() > 0 && (cycle_no - sb[0].start) > 200) begin
                    check("done_watchdog", 32'(0), 32'(1));
                    void'(sb.pop_front());
                end
            end
            prev_o = cur;
        end
    end

    // ---------------- driver helpers
    task automatic set_in(input logic r, input logic [5:0] o, input logic m);
        run = r; opcode = o; mem_ready = m; zero = 1'($urandom);
        #2;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic step(input logic r, input logic [5:0] o, input logic m);
        set_in(r, o, m);
        tick();
    endtask
    function automatic logic rb();
        return 1'($urandom);
    endfunction
    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction
    function automatic int pick_wait();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    logic [5:0] legal_ops [8] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h0a};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [5:0] op;
        int fw, mw, g;
        logic nr;
        outs_t z;
        z = '0;

        // Reset state
        #3;
        check("reset_outs", 32'(sample()), 32'(z));
        check("reset_err", 32'(err), 32'(0));
        do_reset();

        // Directed R-type, zero-wait memory
        set_in(1, 6'h00, 1);
        check("idle_outs", 32'(sample()), 32'(z));
        tick();
        set_in(1, 6'h00, 1); check("r_fetch", 32'(sample()), 32'(o_fetch(1))); tick();
        set_in(1, 6'h00, 1); check("r_decode", 32'(sample()), 32'(o_decode())); tick();
        set_in(1, 6'h00, 1); check("r_exec", 32'(sample()), 32'(o_alu(2'b00, 3'b010))); tick();
        set_in(0, 6'h00, 1); check("r_alu_wb", 32'(sample()), 32'(o_wb(1, 0))); tick();
        set_in(0, 6'h00, 0); check("r_back_idle", 32'(sample()), 32'(z)); tick();

        // Random stream checked through the scoreboard
        sb_en = 1'b1;
        step(1, ro(), rb());
        for (int n = 0; n < 160; n++) begin
            op = legal_ops[$urandom_range(0, 7)];
            fw = pick_wait();
            mw = pick_wait();
            nr = (n == 159) ? 1'b0 : ($urandom_range(0, 3) != 0);
            sb.push_back(model(op, fw, mw, cycle_no));
            for (int i = 0; i < fw; i++) step(rb(), ro(), 0);
            step(rb(), ro(), 1);
            step(rb(), op, rb());
            case (op)
                6'h23: begin
                    step(rb(), ro(), rb());
                    for (int i = 0; i < mw; i++) step(rb(), ro(), 0);
                    step(rb(), ro(), 1);
                    step(nr, ro(), rb());
                end
                6'h2b: begin
                    step(rb(), ro(), rb());
                    for (int i = 0; i < mw; i++) step(rb(), ro(), 0);
                    step(nr, ro(), 1);
                end
                6'h04: step(nr, ro(), rb());
                default: begin
                    step(rb(), ro(), rb());
                    step(nr, ro(), rb());
                end
            endcase
            if (!nr && n != 159) begin
                g = $urandom_range(1, 3);
                for (int i = 1; i < g; i++) step(0, ro(), rb());
                step(1, ro(), rb());
            end
        end
        step(0, ro(), 0);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        sb_en = 1'b0;

        // Illegal opcode trap
        do_reset();
        step(1, 6'h00, 0);
        step(0, 6'h00, 1);
        step(0, 6'h3f, 0);
        for (int i = 0; i < 20; i++) begin
            set_in(1, ro(), rb());
            check("trap_outs", 32'(sample()), 32'(z));
            check("trap_err01", 32'(err), 32'(2'b01));
            tick();
        end
        do_reset();
        check("err_cleared", 32'(err), 32'(0));

        // Memory timeout in FETCH: 16 stalled cycles trap
        step(1, 6'h00, 0);
        for (int i = 0; i < 16; i++) begin
            set_in(0, ro(), 0);
            if (i == 15) check("fetch_cycle16_live", 32'(sample()), 32'(o_fetch(0)));
            tick();
        end
        set_in(0, ro(), 1);
        check("timeout_err10", 32'(err), 32'(2'b10));
        check("timeout_outs", 32'(sample()), 32'(z));

        // Ready on exactly the 16th cycle wins
        do_reset();
        step(1, 6'h00, 0);
        for (int i = 0; i < 15; i++) step(0, ro(), 0);
        set_in(0, 6'h00, 1);
        check("ready16_irwrite", 32'(IRWrite), 32'(1));
        tick();
        set_in(0, 6'h00, 0);
        check("ready16_decode", 32'(sample()), 32'(o_decode()));
        check("ready16_no_err", 32'(err), 32'(0));

        // Reset in the write-back cycle kills the register write at once
        do_reset();
        step(1, 6'h00, 0);
        step(0, 6'h00, 1);
        step(0, 6'h23, 0);
        step(0, 6'h00, 0);
        step(0, 6'h00, 1);
        set_in(0, 6'h00, 0);
        check("lw_wb_before_reset", 32'(sample()), 32'(o_wb(0, 1)));
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 32'(sample()), 32'(z));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_in(0, 6'h00, 0);
        check("after_reset_idle", 32'(sample()), 32'(z));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
